// File: rtl/params_pkg.sv
// Shared address-width defaults for the MMU page-table-walk path.
package params_pkg;
  localparam int VADDR_WIDTH = 32;
  localparam int PADDR_WIDTH = 32;
endpackage

// File: rtl/ptw_arbiter_if.sv
// Bus bundle between the two TLB requesters, the walker and ptw_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface ptw_arbiter_if #(
  parameter int VADDR_WIDTH = params_pkg::VADDR_WIDTH,
  parameter int PADDR_WIDTH = params_pkg::PADDR_WIDTH
);
  logic [1:0]               req_i;
  logic [2*VADDR_WIDTH-1:0] vaddr_i;
  logic                     flush_i;
  logic [1:0]               gnt_o;
  logic [1:0]               rsp_valid_o;
  logic                     rsp_error_o;
  logic [PADDR_WIDTH-1:0]   rsp_paddr_o;
  logic                     ptw_req_o;
  logic [VADDR_WIDTH-1:0]   ptw_vaddr_o;
  logic                     ptw_valid_i;
  logic                     ptw_error_i;
  logic [PADDR_WIDTH-1:0]   ptw_paddr_i;
  logic                     busy_o;

  modport slave (
    input  req_i, vaddr_i, flush_i, ptw_valid_i, ptw_error_i, ptw_paddr_i,
    output gnt_o, rsp_valid_o, rsp_error_o, rsp_paddr_o, ptw_req_o, ptw_vaddr_o, busy_o
  );

  modport master (
    output req_i, vaddr_i, flush_i, ptw_valid_i, ptw_error_i, ptw_paddr_i,
    input  gnt_o, rsp_valid_o, rsp_error_o, rsp_paddr_o, ptw_req_o, ptw_vaddr_o, busy_o
  );
endinterface

// File: rtl/ptw_arbiter.sv
// Round-robin arbiter sharing one page-table walker between ITLB (id 0) and DTLB (id 1).
// One walk at a time: IDLE grants, WALK waits WALK_LATENCY cycles, RESP returns one pulse.
module ptw_arbiter #(
  parameter int VADDR_WIDTH  = params_pkg::VADDR_WIDTH,
  parameter int PADDR_WIDTH  = params_pkg::PADDR_WIDTH,
  parameter int WALK_LATENCY = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  ptw_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(WALK_LATENCY - 1);

  state_e                 state_q;
  logic                   id_q;
  logic                   rr_q;
  logic [3:0]             cnt_q;
  logic [VADDR_WIDTH-1:0] vaddr_q;
  logic                   err_q;
  logic [PADDR_WIDTH-1:0] paddr_q;

  logic                   gnt_valid_d;
  logic                   gnt_id_d;
  logic [VADDR_WIDTH-1:0] req_vaddr_d;
  logic                   cap_err_d;
  logic [PADDR_WIDTH-1:0] cap_paddr_d;
  logic                   rsp_live_d;

  // Arbitration; gated by rst_ni so no grant leaks out while reset is held.
  always_comb begin
    gnt_valid_d = 1'b0;
    gnt_id_d    = 1'b0;
    if (rst_ni && (state_q == IDLE) && !bus.flush_i) begin
      case (bus.req_i)
        2'b01: begin
          gnt_valid_d = 1'b1;
          gnt_id_d    = 1'b0;
        end
        2'b10: begin
          gnt_valid_d = 1'b1;
          gnt_id_d    = 1'b1;
        end
        2'b11: begin
          gnt_valid_d = 1'b1;
          gnt_id_d    = rr_q;
        end
        default: begin
          gnt_valid_d = 1'b0;
          gnt_id_d    = 1'b0;
        end
      endcase
    end else begin
      gnt_valid_d = 1'b0;
      gnt_id_d    = 1'b0;
    end
  end

  // Walker result capture: a missing valid is a timeout fault, faults carry no address.
  always_comb begin
    req_vaddr_d = '0;
    if (gnt_id_d) begin
      req_vaddr_d = bus.vaddr_i[2*VADDR_WIDTH-1:VADDR_WIDTH];
    end else begin
      req_vaddr_d = bus.vaddr_i[VADDR_WIDTH-1:0];
    end
    cap_err_d   = bus.ptw_error_i | ~bus.ptw_valid_i;
    cap_paddr_d = '0;
    if (cap_err_d) begin
      cap_paddr_d = '0;
    end else begin
      cap_paddr_d = bus.ptw_paddr_i;
    end
  end

  // Walk sequencer; rr_q flips on RESP entry so a later flush does not undo fairness.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= 4'd0;
      vaddr_q <= '0;
      err_q   <= 1'b0;
      paddr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid_d) begin
            state_q <= WALK;
            id_q    <= gnt_id_d;
            vaddr_q <= req_vaddr_d;
            cnt_q   <= CNT_LOAD;
          end
        end
        WALK: begin
          if (bus.flush_i) begin
            state_q <= IDLE;
          end else if (cnt_q == 4'd0) begin
            err_q   <= cap_err_d;
            paddr_q <= cap_paddr_d;
            rr_q    <= ~id_q;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // A flush in the RESP cycle kills the pulse in that same cycle.
  assign rsp_live_d      = (state_q == RESP) && !bus.flush_i;
  assign bus.gnt_o       = gnt_valid_d ? (gnt_id_d ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_valid_o = rsp_live_d ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_error_o = rsp_live_d ? err_q : 1'b0;
  assign bus.rsp_paddr_o = rsp_live_d ? paddr_q : '0;
  assign bus.ptw_req_o   = (state_q == WALK);
  assign bus.ptw_vaddr_o = (state_q == WALK) ? vaddr_q : '0;
  assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_ptw_arbiter.sv
// Directed bench for ptw_arbiter: expected responses are queued at grant time
// and popped whenever the DUT pulses rsp_valid_o.
module tb_ptw_arbiter;
  localparam int VW  = params_pkg::VADDR_WIDTH;
  localparam int PW  = params_pkg::PADDR_WIDTH;
  localparam int LAT = 2;

  typedef struct packed {
    logic [1:0]    v;
    logic          e;
    logic [PW-1:0] pa;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  ptw_arbiter_if #(.VADDR_WIDTH(VW), .PADDR_WIDTH(PW)) bus ();

  ptw_arbiter #(.VADDR_WIDTH(VW), .PADDR_WIDTH(PW), .WALK_LATENCY(LAT)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Settle, then score any response pulse against the queue.
  task automatic sample();
    exp_t e;
    #1;
    if (bus.rsp_valid_o !== 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", bus.rsp_valid_o, 2'b00);
      end else begin
        e = sb.pop_front();
        chk("sb_valid", bus.rsp_valid_o, e.v);
        chk("sb_error", bus.rsp_error_o, e.e);
        chk("sb_paddr", bus.rsp_paddr_o, e.pa);
      end
    end else begin
      chk("quiet_rsp", {bus.rsp_error_o, bus.rsp_paddr_o}, 128'd0);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {bus.gnt_o, bus.rsp_valid_o, bus.rsp_error_o, bus.rsp_paddr_o,
            bus.ptw_req_o, bus.ptw_vaddr_o, bus.busy_o};
  endfunction

  task automatic walk(input logic id, input logic [VW-1:0] va, input logic pv, input logic pe,
                      input logic [PW-1:0] pp, input logic hold, input logic [1:0] also);
    logic [1:0] oh;
    exp_t       e;
    oh   = id ? 2'b10 : 2'b01;
    e.v  = oh;
    e.e  = pe | ~pv;
    e.pa = e.e ? {PW{1'b0}} : pp;
    next();
    bus.flush_i = 1'b0;
    bus.req_i   = bus.req_i | also | oh;
    if (id) bus.vaddr_i[2*VW-1:VW] = va;
    else    bus.vaddr_i[VW-1:0]    = va;
    sample();
    chk("grant", bus.gnt_o, oh);
    chk("busy_idle", bus.busy_o, 1'b0);
    sb.push_back(e);
    for (int k = 1; k <= LAT; k++) begin
      next();
      if (k == 1 && !hold) begin
        bus.req_i = bus.req_i & ~oh;
        if (id) bus.vaddr_i[2*VW-1:VW] = ~va;
        else    bus.vaddr_i[VW-1:0]    = ~va;
      end
      if (k == LAT) begin
        bus.ptw_valid_i = pv;
        bus.ptw_error_i = pe;
        bus.ptw_paddr_i = pp;
      end else begin
        bus.ptw_valid_i = ~pv;
        bus.ptw_error_i = ~pe;
        bus.ptw_paddr_i = ~pp;
      end
      sample();
      chk("walk_req", bus.ptw_req_o, 1'b1);
      chk("walk_vaddr", bus.ptw_vaddr_o, va);
      chk("walk_gnt", bus.gnt_o, 2'b00);
      chk("walk_busy", bus.busy_o, 1'b1);
    end
    next();
    bus.ptw_valid_i = 1'b0;
    bus.ptw_error_i = 1'b0;
    bus.ptw_paddr_i = '0;
    sample();
    chk("rsp_timing", bus.rsp_valid_o, oh);
    chk("rsp_ptw_req", bus.ptw_req_o, 1'b0);
    chk("rsp_ptw_vaddr", bus.ptw_vaddr_o, 128'd0);
    chk("rsp_gnt", bus.gnt_o, 2'b00);
  endtask

  initial begin
    bus.req_i       = 2'b11;
    bus.vaddr_i     = '0;
    bus.flush_i     = 1'b0;
    bus.ptw_valid_i = 1'b0;
    bus.ptw_error_i = 1'b0;
    bus.ptw_paddr_i = '0;

    // Reset: everything quiet even with both requests high.
    sample();
    chk("reset_outs", all_outs(), 128'd0);
    next();
    sample();
    chk("reset_outs_hold", all_outs(), 128'd0);
    bus.req_i = 2'b00;
    rst_n     = 1'b1;
    sample();
    chk("post_reset_gnt", bus.gnt_o, 2'b00);

    // Contention from reset: ITLB at T, DTLB at T+4, ITLB at T+8.
    walk(1'b0, 32'h0000_1100, 1'b1, 1'b0, 32'h0000_0A00, 1'b1, 2'b11);
    walk(1'b1, 32'h0000_2200, 1'b1, 1'b0, 32'h0000_0B00, 1'b1, 2'b00);
    walk(1'b0, 32'h0000_1100, 1'b1, 1'b0, 32'h0000_0C00, 1'b1, 2'b00);
    bus.req_i = 2'b00;

    // Basic ITLB walk, DTLB fault, ITLB timeout.
    walk(1'b0, 32'h0000_1000, 1'b1, 1'b0, 32'h0000_5000, 1'b0, 2'b00);
    walk(1'b1, 32'h0000_2000, 1'b1, 1'b1, 32'h0000_DEAD, 1'b0, 2'b00);
    walk(1'b0, 32'h0000_3000, 1'b0, 1'b0, 32'h0000_7777, 1'b0, 2'b00);

    // Flush in IDLE suppresses the grant; next cycle is arbitrated normally.
    next();
    bus.req_i           = 2'b01;
    bus.vaddr_i[VW-1:0] = 32'h0000_4000;
    bus.flush_i         = 1'b1;
    sample();
    chk("flush_idle_gnt", bus.gnt_o, 2'b00);
    chk("flush_idle_busy", bus.busy_o, 1'b0);
    walk(1'b0, 32'h0000_4000, 1'b1, 1'b0, 32'h0000_1234, 1'b0, 2'b00);

    // Flush mid-WALK at T+2: no response, new pair granted at T+3 (rr_q still 1).
    next();
    bus.req_i           = 2'b01;
    bus.vaddr_i[VW-1:0] = 32'h0000_5000;
    sample();
    chk("fw_grant", bus.gnt_o, 2'b01);
    next();
    bus.req_i = 2'b00;
    sample();
    chk("fw_walk", bus.ptw_req_o, 1'b1);
    next();
    bus.flush_i     = 1'b1;
    bus.ptw_valid_i = 1'b1;
    bus.ptw_paddr_i = 32'h0000_5555;
    sample();
    chk("fw_walk2", bus.ptw_req_o, 1'b1);
    walk(1'b1, 32'h0000_6000, 1'b1, 1'b0, 32'h0000_ABCD, 1'b0, 2'b01);
    bus.req_i = 2'b00;

    // Flush in RESP: pulse suppressed, yet rr_q still moves past ITLB.
    next();
    bus.req_i           = 2'b01;
    bus.vaddr_i[VW-1:0] = 32'h0000_8000;
    sample();
    chk("fr_grant", bus.gnt_o, 2'b01);
    next();
    bus.req_i = 2'b00;
    sample();
    next();
    bus.ptw_valid_i = 1'b1;
    bus.ptw_paddr_i = 32'h0000_9999;
    sample();
    next();
    bus.flush_i     = 1'b1;
    bus.ptw_valid_i = 1'b0;
    bus.ptw_paddr_i = '0;
    sample();
    chk("fr_no_rsp", bus.rsp_valid_o, 2'b00);
    chk("fr_busy", bus.busy_o, 1'b1);
    walk(1'b1, 32'h0000_7000, 1'b1, 1'b0, 32'h0000_0777, 1'b0, 2'b01);
    bus.req_i = 2'b00;

    // Leave rr_q=1, then reset during a DTLB walk.
    walk(1'b0, 32'h0000_A000, 1'b1, 1'b0, 32'h0000_1111, 1'b0, 2'b00);
    next();
    bus.req_i                = 2'b10;
    bus.vaddr_i[2*VW-1:VW]   = 32'h0000_B000;
    sample();
    chk("rm_grant", bus.gnt_o, 2'b10);
    next();
    rst_n     = 1'b0;
    bus.req_i = 2'b11;
    sample();
    chk("rm_outs", all_outs(), 128'd0);
    next();
    sample();
    chk("rm_outs_hold", all_outs(), 128'd0);
    bus.req_i = 2'b00;
    rst_n     = 1'b1;
    walk(1'b0, 32'h0000_C000, 1'b1, 1'b0, 32'h0000_2222, 1'b0, 2'b10);
    bus.req_i = 2'b00;
    next();
    sample();
    next();
    sample();
    chk("sb_empty", sb.size(), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
